// File: rtl/clk_fwd_div_pkg.sv
// Shared defaults and sizing helper for the clock forwarding divider.
package clk_fwd_div_pkg;

  localparam int DIVISOR_DEF     = 8;
  localparam int LOCK_CYCLES_DEF = 16;

  // A divide-by-2 counter still needs one bit.
  function automatic int cnt_width(input int d);
    return (d <= 2) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/clk_fwd_div_if.sv
// Control inputs and clock/strobe outputs of clk_fwd_div.
interface clk_fwd_div_if;

  logic sync_clr;
  logic gate_en;
  logic ce;
  logic div_clk;
  logic fwd_clk;
  logic locked;

  modport master (
    output sync_clr, gate_en,
    input  ce, div_clk, fwd_clk, locked
  );

  modport slave (
    input  sync_clr, gate_en,
    output ce, div_clk, fwd_clk, locked
  );

endinterface

// File: rtl/ddr_out_cell.sv
// DDR output cell: d1 captured on the rising edge, d2 on the falling edge,
// the clock selects which stage drives the pin.
module ddr_out_cell (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d1_i,
  input  logic d2_i,
  output logic q_o
);

  logic r_q;
  logic f_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_q <= 1'b0;
    else          r_q <= d1_i;
  end

  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) f_q <= 1'b0;
    else          f_q <= d2_i;
  end

  assign q_o = clk_i ? r_q : f_q;

endmodule

// File: rtl/clk_fwd_div.sv
// Integer clock divider with CE strobe, registered divided clock, startup
// lock indicator and a gated DDR-forwarded copy of the input clock.
module clk_fwd_div
  import clk_fwd_div_pkg::*;
#(
  parameter int DIVISOR     = DIVISOR_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  clk_fwd_div_if.slave bus
);

  localparam int              CW        = cnt_width(DIVISOR);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(DIVISOR - 1);
  localparam logic [CW-1:0]   CNT_HALF  = CW'(DIVISOR / 2);
  localparam logic [7:0]      LOCK_LAST = 8'(LOCK_CYCLES);

  logic [1:0]    rst_sync_q;
  logic          run;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ce_q, ce_d;
  logic          div_q, div_d;
  logic [7:0]    lock_cnt_q, lock_cnt_d;
  logic          locked_q, locked_d;
  logic          wrap;

  // Internal reset releases on the second rising edge after RST_N goes high;
  // the first count happens on the edge after that.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign run  = rst_sync_q[1];
  assign wrap = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d      = cnt_q;
    ce_d       = 1'b0;
    div_d      = div_q;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (run) begin
      cnt_d = (wrap || bus.sync_clr) ? '0 : cnt_q + 1'b1;
      ce_d  = wrap && !bus.sync_clr;
      div_d = (cnt_d < CNT_HALF);
      if (lock_cnt_q != LOCK_LAST) lock_cnt_d = lock_cnt_q + 8'd1;
      locked_d = locked_q | (lock_cnt_q == LOCK_LAST);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q      <= '0;
      ce_q       <= 1'b0;
      div_q      <= 1'b0;
      lock_cnt_q <= 8'd0;
      locked_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ce_q       <= ce_d;
      div_q      <= div_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  // Falling stage is tied low so only full high phases of the clock pass.
  ddr_out_cell u_ddr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d1_i    (bus.gate_en & locked_q),
    .d2_i    (1'b0),
    .q_o     (bus.fwd_clk)
  );

  assign bus.ce      = ce_q;
  assign bus.div_clk = div_q;
  assign bus.locked  = locked_q;

endmodule

// File: tb/tb_clk_fwd_div.sv
// Directed bench: DIVISOR=8/LOCK=16 and DIVISOR=3/LOCK=4 instances side by side.
module tb_clk_fwd_div;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   k;
  int   b8;

  clk_fwd_div_if if8 ();
  clk_fwd_div_if if3 ();

  clk_fwd_div #(.DIVISOR(8), .LOCK_CYCLES(16)) dut8 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (if8)
  );

  clk_fwd_div #(.DIVISOR(3), .LOCK_CYCLES(4)) dut3 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after a counting edge; k counts edges since counting began.
  task automatic check_main();
    int c8;
    int c3;
    c8 = (k - b8) % 8;
    c3 = k % 3;
    chk("ce8",     32'(if8.ce),      32'(c8 == 0));
    chk("div8",    32'(if8.div_clk), 32'(c8 < 4));
    chk("ce3",     32'(if3.ce),      32'(c3 == 0));
    chk("div3",    32'(if3.div_clk), 32'(c3 == 0));
    chk("locked8", 32'(if8.locked),  32'(k >= 17));
    chk("locked3", 32'(if3.locked),  32'(k >= 5));
    chk("fwd8_hi", 32'(if8.fwd_clk), 32'(k >= 18));
    #5;
    chk("fwd8_lo", 32'(if8.fwd_clk), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    k     = 0;
    b8    = 0;
    rst_n = 1'b0;
    if8.sync_clr = 1'b0;
    if8.gate_en  = 1'b1;
    if3.sync_clr = 1'b0;
    if3.gate_en  = 1'b1;

    repeat (3) tick();
    chk("rst_ce8",     32'(if8.ce),      32'd0);
    chk("rst_div8",    32'(if8.div_clk), 32'd0);
    chk("rst_locked8", 32'(if8.locked),  32'd0);
    chk("rst_fwd8",    32'(if8.fwd_clk), 32'd0);
    chk("rst_ce3",     32'(if3.ce),      32'd0);
    chk("rst_div3",    32'(if3.div_clk), 32'd0);

    rst_n = 1'b1;
    repeat (2) begin
      tick();
      chk("idle_ce8",  32'(if8.ce),      32'd0);
      chk("idle_div8", 32'(if8.div_clk), 32'd0);
    end

    // Free-running: 330 edges give 110 periods of the divide-by-3 instance.
    for (int i = 0; i < 330; i++) begin
      tick();
      k++;
      check_main();
    end

    // Gate changes mid high phase must not truncate or start a pulse.
    tick(); k++;
    chk("gate_on_start", 32'(if8.fwd_clk), 32'd1);
    #1 if8.gate_en = 1'b0;
    #1 chk("gate_off_hold", 32'(if8.fwd_clk), 32'd1);
    #4 chk("gate_off_low", 32'(if8.fwd_clk), 32'd0);
    tick(); k++;
    chk("gate_off_edge", 32'(if8.fwd_clk), 32'd0);
    #1 if8.gate_en = 1'b1;
    #1 chk("gate_on_nopulse", 32'(if8.fwd_clk), 32'd0);
    tick(); k++;
    chk("gate_on_edge", 32'(if8.fwd_clk), 32'd1);

    // SYNC_CLR at cnt=5.
    while ((k - b8) % 8 != 5) begin tick(); k++; end
    if8.sync_clr = 1'b1;
    tick(); k++; b8 = k;
    if8.sync_clr = 1'b0;
    chk("clr_ce8",     32'(if8.ce),      32'd0);
    chk("clr_div8",    32'(if8.div_clk), 32'd1);
    chk("clr_locked8", 32'(if8.locked),  32'd1);
    chk("clr_fwd8",    32'(if8.fwd_clk), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      tick(); k++;
      chk("postclr_ce8",  32'(if8.ce),      32'(i == 8));
      chk("postclr_div8", 32'(if8.div_clk), 32'((i % 8) < 4));
      chk("postclr_lock", 32'(if8.locked),  32'd1);
    end

    // SYNC_CLR coinciding with the wrap: no CE may be produced.
    while ((k - b8) % 8 != 7) begin tick(); k++; end
    if8.sync_clr = 1'b1;
    tick(); k++; b8 = k;
    if8.sync_clr = 1'b0;
    chk("clrwrap_ce8",  32'(if8.ce),      32'd0);
    chk("clrwrap_div8", 32'(if8.div_clk), 32'd1);
    tick(); k++;
    chk("clrwrap_ce8_next",  32'(if8.ce),      32'd0);
    chk("clrwrap_div8_next", 32'(if8.div_clk), 32'd1);

    // Asynchronous reset at cnt=6, during the high phase of the clock.
    while ((k - b8) % 8 != 6) begin tick(); k++; end
    #2;
    chk("pre_arst_fwd8", 32'(if8.fwd_clk), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_ce8",     32'(if8.ce),      32'd0);
    chk("arst_div8",    32'(if8.div_clk), 32'd0);
    chk("arst_locked8", 32'(if8.locked),  32'd0);
    chk("arst_fwd8",    32'(if8.fwd_clk), 32'd0);
    chk("arst_locked3", 32'(if3.locked),  32'd0);
    repeat (2) begin
      tick();
      chk("arst_hold_ce8",  32'(if8.ce),      32'd0);
      chk("arst_hold_fwd8", 32'(if8.fwd_clk), 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      tick();
      chk("idle2_ce8",  32'(if8.ce),      32'd0);
      chk("idle2_div8", 32'(if8.div_clk), 32'd0);
    end
    k  = 0;
    b8 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      k++;
      check_main();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
